// File: rtl/ex_ctrl.sv
// Execute-stage sequencing controller: turns ALU branch/exception results into
// redirect, flush/stall, trap handoff and sticky halt. Optional counters: CTRL_STATS_EN.
`ifndef TRAP_OVERFLOW
`define TRAP_OVERFLOW 8'h0C
`endif
`ifndef TRAP_STALL
`define TRAP_STALL 8'hFE
`endif

module ex_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR  = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        alu_br_enable,
  input  logic [31:0] alu_br_target,
  input  logic [7:0]  alu_exception,
  input  logic        trap_ack,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        flush,
  output logic        stall,
  output logic        trap_valid,
  output logic [7:0]  trap_code,
  output logic [31:0] epc,
`ifdef CTRL_STATS_EN
  output logic [31:0] br_count,
  output logic [31:0] trap_count,
`endif
  output logic        halted
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_TRAP, S_HALT} state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic        pc_redirect_q, flush_q, stall_q, trap_valid_q, halted_q;
  logic [31:0] redirect_target_q, epc_q;
  logic [7:0]  trap_code_q;
`ifdef CTRL_STATS_EN
  logic [31:0] br_cnt_q, trap_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_RUN;
      cnt_q             <= '0;
      pc_redirect_q     <= 1'b0;
      redirect_target_q <= '0;
      flush_q           <= 1'b0;
      stall_q           <= 1'b0;
      trap_valid_q      <= 1'b0;
      trap_code_q       <= '0;
      epc_q             <= '0;
      halted_q          <= 1'b0;
`ifdef CTRL_STATS_EN
      br_cnt_q          <= '0;
      trap_cnt_q        <= '0;
`endif
    end else begin
      // Redirect is a single-cycle pulse; only the entry into FLUSH raises it.
      pc_redirect_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (ex_valid) begin
            if (alu_exception == `TRAP_STALL) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              stall_q  <= 1'b1;
              flush_q  <= 1'b1;
            end else if (alu_exception != 8'd0) begin
              // Exceptions win over a same-cycle branch; unknown codes pass through.
              state_q      <= S_TRAP;
              trap_valid_q <= 1'b1;
              stall_q      <= 1'b1;
              trap_code_q  <= alu_exception;
              epc_q        <= ex_pc;
`ifdef CTRL_STATS_EN
              trap_cnt_q   <= trap_cnt_q + 32'd1;
`endif
            end else if (alu_br_enable) begin
              state_q           <= S_FLUSH;
              pc_redirect_q     <= 1'b1;
              redirect_target_q <= alu_br_target;
              flush_q           <= 1'b1;
              cnt_q             <= CNT_INIT;
`ifdef CTRL_STATS_EN
              br_cnt_q          <= br_cnt_q + 32'd1;
`endif
            end
          end
        end
        S_FLUSH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_RUN;
            flush_q <= 1'b0;
          end
        end
        S_TRAP: begin
          if (trap_ack) begin
            state_q           <= S_FLUSH;
            trap_valid_q      <= 1'b0;
            stall_q           <= 1'b0;
            pc_redirect_q     <= 1'b1;
            redirect_target_q <= TRAP_VECTOR;
            flush_q           <= 1'b1;
            cnt_q             <= CNT_INIT;
          end
        end
        S_HALT: ;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pc_redirect     = pc_redirect_q;
  assign redirect_target = redirect_target_q;
  assign flush           = flush_q;
  assign stall           = stall_q;
  assign trap_valid      = trap_valid_q;
  assign trap_code       = trap_code_q;
  assign epc             = epc_q;
  assign halted          = halted_q;
`ifdef CTRL_STATS_EN
  assign br_count        = br_cnt_q;
  assign trap_count      = trap_cnt_q;
`endif

endmodule

// File: tb/tb_ex_ctrl.sv
// Directed self-checking bench for ex_ctrl (default FLUSH_CYCLES=2).
`ifndef TRAP_OVERFLOW
`define TRAP_OVERFLOW 8'h0C
`endif
`ifndef TRAP_STALL
`define TRAP_STALL 8'hFE
`endif

module tb_ex_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        alu_br_enable;
  logic [31:0] alu_br_target;
  logic [7:0]  alu_exception;
  logic        trap_ack;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        flush, stall, trap_valid, halted;
  logic [7:0]  trap_code;
  logic [31:0] epc;
`ifdef CTRL_STATS_EN
  logic [31:0] br_count, trap_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_br_enable(alu_br_enable), .alu_br_target(alu_br_target),
    .alu_exception(alu_exception), .trap_ack(trap_ack),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .flush(flush), .stall(stall), .trap_valid(trap_valid),
    .trap_code(trap_code), .epc(epc),
`ifdef CTRL_STATS_EN
    .br_count(br_count), .trap_count(trap_count),
`endif
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    ex_valid = 1'b0; alu_br_enable = 1'b0; alu_exception = 8'd0;
    trap_ack = 1'b0; ex_pc = 32'd0; alu_br_target = 32'd0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".redir"},  32'(pc_redirect), 32'd0);
    chk({tag, ".target"}, redirect_target, 32'd0);
    chk({tag, ".flush"},  32'(flush), 32'd0);
    chk({tag, ".stall"},  32'(stall), 32'd0);
    chk({tag, ".tvalid"}, 32'(trap_valid), 32'd0);
    chk({tag, ".tcode"},  32'(trap_code), 32'd0);
    chk({tag, ".epc"},    epc, 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  task automatic branch(input logic [31:0] tgt);
    ex_valid = 1'b1; alu_br_enable = 1'b1; alu_br_target = tgt; alu_exception = 8'd0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // Idle gating: nothing happens without ex_valid.
    alu_br_enable = 1'b1; alu_exception = `TRAP_OVERFLOW; ex_pc = 32'h00400004;
    tick();
    chk_zero("idle");
    tick();
    chk_zero("idle2");

    // Branch and squashed follow-up branch.
    branch(32'h00400020);
    tick();
    chk("br.redir", 32'(pc_redirect), 32'd1);
    chk("br.target", redirect_target, 32'h00400020);
    chk("br.flush1", 32'(flush), 32'd1);
    branch(32'h0);
    tick();
    chk("br.redir2", 32'(pc_redirect), 32'd0);
    chk("br.flush2", 32'(flush), 32'd1);
    chk("br.hold", redirect_target, 32'h00400020);
    idle_in();
    tick();
    chk("br.flush3", 32'(flush), 32'd0);

    // Overflow with simultaneous branch: trap wins, no redirect.
    ex_valid = 1'b1; alu_exception = `TRAP_OVERFLOW; alu_br_enable = 1'b1;
    alu_br_target = 32'h00001000; ex_pc = 32'h00400010;
    tick();
    chk("ovf.tvalid", 32'(trap_valid), 32'd1);
    chk("ovf.stall", 32'(stall), 32'd1);
    chk("ovf.epc", epc, 32'h00400010);
    chk("ovf.code", 32'(trap_code), 32'(`TRAP_OVERFLOW));
    chk("ovf.redir", 32'(pc_redirect), 32'd0);
    chk("ovf.flush", 32'(flush), 32'd0);
    // Inputs keep changing while trapped; trap state must not move.
    ex_pc = 32'h00400099; alu_exception = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf.hold.tv", 32'(trap_valid), 32'd1);
      chk("ovf.hold.epc", epc, 32'h00400010);
      chk("ovf.hold.code", 32'(trap_code), 32'(`TRAP_OVERFLOW));
      chk("ovf.hold.redir", 32'(pc_redirect), 32'd0);
    end
    idle_in();
    trap_ack = 1'b1;
    tick();
    chk("ack.redir", 32'(pc_redirect), 32'd1);
    chk("ack.target", redirect_target, 32'h80000180);
    chk("ack.flush", 32'(flush), 32'd1);
    chk("ack.tvalid", 32'(trap_valid), 32'd0);
    chk("ack.stall", 32'(stall), 32'd0);
    chk("ack.epc", epc, 32'h00400010);
    trap_ack = 1'b0;
    tick();
    chk("ack.redir2", 32'(pc_redirect), 32'd0);
    chk("ack.flush2", 32'(flush), 32'd1);
    tick();
    chk("ack.flush3", 32'(flush), 32'd0);

    // Unknown code passes through; trap_ack outside TRAP is ignored.
    trap_ack = 1'b1;
    tick();
    chk("stray.ack", 32'(pc_redirect), 32'd0);
    trap_ack = 1'b0;
    ex_valid = 1'b1; alu_exception = 8'h55; ex_pc = 32'h00400030;
    tick();
    chk("unk.code", 32'(trap_code), 32'h55);
    chk("unk.epc", epc, 32'h00400030);
    idle_in();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    tick(); tick();
    chk("unk.done", 32'(flush), 32'd0);

    // Reset in the second FLUSH cycle.
    branch(32'h00400040);
    tick();
    idle_in();
    tick();
    chk("rfl.flush", 32'(flush), 32'd1);
    rst = 1'b1;
    tick();
    chk_zero("rfl");
    rst = 1'b0;
    branch(32'h00401234);
    tick();
    chk("rfl.redir", 32'(pc_redirect), 32'd1);
    chk("rfl.target", redirect_target, 32'h00401234);
    idle_in();
    tick(); tick();

    // Reset while trap pending.
    ex_valid = 1'b1; alu_exception = `TRAP_OVERFLOW; ex_pc = 32'h00400050;
    tick();
    chk("rtr.tvalid", 32'(trap_valid), 32'd1);
    idle_in();
    rst = 1'b1;
    tick();
    chk_zero("rtr");
    rst = 1'b0;
    branch(32'h00405678);
    tick();
    chk("rtr.redir", 32'(pc_redirect), 32'd1);
    chk("rtr.target", redirect_target, 32'h00405678);
    idle_in();
    tick(); tick();

    // Halt is terminal until reset.
    ex_valid = 1'b1; alu_exception = `TRAP_STALL; alu_br_enable = 1'b1;
    alu_br_target = 32'h00000800;
    tick();
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.stall", 32'(stall), 32'd1);
    chk("halt.flush", 32'(flush), 32'd1);
    chk("halt.tvalid", 32'(trap_valid), 32'd0);
    chk("halt.redir", 32'(pc_redirect), 32'd0);
    alu_exception = 8'd0;
    trap_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alu_br_target = 32'h1000 + 32'(i);
      tick();
      chk("halt.hold.h", 32'(halted), 32'd1);
      chk("halt.hold.s", 32'(stall), 32'd1);
      chk("halt.hold.f", 32'(flush), 32'd1);
      chk("halt.hold.r", 32'(pc_redirect), 32'd0);
    end
    idle_in();
    rst = 1'b1;
    tick();
    chk_zero("halt.rst");
    rst = 1'b0;
    tick();

`ifdef CTRL_STATS_EN
    chk("st.br0", br_count, 32'd0);
    chk("st.tr0", trap_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      branch(32'h00400100 + 32'(i));
      tick();
      idle_in();
      tick(); tick();
    end
    ex_valid = 1'b1; alu_exception = `TRAP_OVERFLOW;
    tick();
    idle_in();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    tick(); tick();
    chk("st.br3", br_count, 32'd3);
    chk("st.tr1", trap_count, 32'd1);
    @(negedge clk);
    force dut.br_cnt_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.br_cnt_q;
    branch(32'h00400200);
    tick();
    chk("st.wrap", br_count, 32'd0);
    idle_in();
    tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything beyond this is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
